// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and WB-stage bypass.
// Build option: define FORWARD_EN to resolve EX-stage hazards by forwarding the WB
// result into the operand muxes. Leave it undefined to resolve them with a one-cycle
// stall instead. The default build (FORWARD_EN undefined) is the stall policy.
module id_ex_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [2:0] id_rs1_addr,
   input  logic [2:0] id_rs2_addr,
   input  logic [7:0] id_rs1_data,
   input  logic [7:0] id_rs2_data,
   input  logic [7:0] id_shamt,
   input  logic       id_shamt_sel,
   input  logic [2:0] id_rd_addr,
   input  logic       id_reg_write,
   input  logic [2:0] id_alu_op,
   input  logic       flush,
   input  logic       wb_reg_write,
   input  logic [2:0] wb_rd_addr,
   input  logic [7:0] wb_data,
   output logic [7:0] ex_rs1_data,
   output logic [7:0] ex_rs2_data,
   output logic [7:0] ex_shamt,
   output logic       ex_fwd1,
   output logic       ex_fwd2,
   output logic       ex_shamt_sel,
   output logic [7:0] ex_fwd_data,
   output logic [2:0] ex_rd_addr,
   output logic       ex_reg_write,
   output logic       ex_valid,
   output logic [2:0] ex_alu_op,
   output logic       id_stall
);

   logic [7:0] ex_rs1_data_q, ex_rs1_data_d;
   logic [7:0] ex_rs2_data_q, ex_rs2_data_d;
   logic [7:0] ex_shamt_q, ex_shamt_d;
   logic       ex_fwd1_q, ex_fwd1_d;
   logic       ex_fwd2_q, ex_fwd2_d;
   logic       ex_shamt_sel_q, ex_shamt_sel_d;
   logic [2:0] ex_rd_addr_q, ex_rd_addr_d;
   logic       ex_reg_write_q, ex_reg_write_d;
   logic       ex_valid_q, ex_valid_d;
   logic [2:0] ex_alu_op_q, ex_alu_op_d;

   logic       hazard1, hazard2;
   logic       bypass1, bypass2;
   logic       fwd1_sel, fwd2_sel;
   logic       stall;
   logic [7:0] rs1_val, rs2_val;

   // Hazard against the producer now in EX, and bypass from the WB write port.
   // r0 is hard-wired zero, so it never participates in either comparison.
   always_comb begin
      hazard1 = id_valid & ex_valid_q & ex_reg_write_q & (id_rs1_addr != 3'd0)
                & (ex_rd_addr_q == id_rs1_addr);
      // A shift by immediate does not read rs2.
      hazard2 = id_valid & ex_valid_q & ex_reg_write_q & (id_rs2_addr != 3'd0)
                & (ex_rd_addr_q == id_rs2_addr) & ~id_shamt_sel;
      bypass1 = wb_reg_write & (wb_rd_addr != 3'd0) & (wb_rd_addr == id_rs1_addr);
      bypass2 = wb_reg_write & (wb_rd_addr != 3'd0) & (wb_rd_addr == id_rs2_addr);
      rs1_val = bypass1 ? wb_data : id_rs1_data;
      rs2_val = bypass2 ? wb_data : id_rs2_data;
   end

`ifdef FORWARD_EN
   // Forwarding policy: never stall; the consumer picks up wb_data in EX.
   always_comb begin
      stall    = 1'b0;
      fwd1_sel = hazard1;
      fwd2_sel = hazard2;
   end
`else
   // Stall policy: one bubble moves the producer to WB, where the bypass covers it.
   always_comb begin
      stall    = (hazard1 | hazard2) & ~flush & ~reset;
      fwd1_sel = 1'b0;
      fwd2_sel = 1'b0;
   end
`endif

   // Next-state selection: flush beats stall beats load. Reset is applied in the register.
   always_comb begin
      ex_rs1_data_d  = ex_rs1_data_q;
      ex_rs2_data_d  = ex_rs2_data_q;
      ex_shamt_d     = ex_shamt_q;
      ex_fwd1_d      = ex_fwd1_q;
      ex_fwd2_d      = ex_fwd2_q;
      ex_shamt_sel_d = ex_shamt_sel_q;
      ex_rd_addr_d   = ex_rd_addr_q;
      ex_reg_write_d = ex_reg_write_q;
      ex_valid_d     = ex_valid_q;
      ex_alu_op_d    = ex_alu_op_q;
      if (flush) begin
         ex_valid_d     = 1'b0;
         ex_reg_write_d = 1'b0;
         ex_fwd1_d      = 1'b0;
         ex_fwd2_d      = 1'b0;
         ex_shamt_sel_d = 1'b0;
      end else if (stall) begin
         // Bubble; data fields keep their old values and are ignored downstream.
         ex_valid_d     = 1'b0;
         ex_reg_write_d = 1'b0;
         ex_fwd1_d      = 1'b0;
         ex_fwd2_d      = 1'b0;
      end else begin
         ex_rs1_data_d  = rs1_val;
         ex_rs2_data_d  = rs2_val;
         ex_shamt_d     = id_shamt;
         ex_fwd1_d      = fwd1_sel;
         ex_fwd2_d      = fwd2_sel;
         ex_shamt_sel_d = id_shamt_sel;
         ex_rd_addr_d   = id_rd_addr;
         ex_reg_write_d = id_reg_write & id_valid;
         ex_valid_d     = id_valid;
         ex_alu_op_d    = id_alu_op;
      end
   end

   // Pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rs1_data_q  <= 8'h00;
         ex_rs2_data_q  <= 8'h00;
         ex_shamt_q     <= 8'h00;
         ex_fwd1_q      <= 1'b0;
         ex_fwd2_q      <= 1'b0;
         ex_shamt_sel_q <= 1'b0;
         ex_rd_addr_q   <= 3'd0;
         ex_reg_write_q <= 1'b0;
         ex_valid_q     <= 1'b0;
         ex_alu_op_q    <= 3'd0;
      end else begin
         ex_rs1_data_q  <= ex_rs1_data_d;
         ex_rs2_data_q  <= ex_rs2_data_d;
         ex_shamt_q     <= ex_shamt_d;
         ex_fwd1_q      <= ex_fwd1_d;
         ex_fwd2_q      <= ex_fwd2_d;
         ex_shamt_sel_q <= ex_shamt_sel_d;
         ex_rd_addr_q   <= ex_rd_addr_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_valid_q     <= ex_valid_d;
         ex_alu_op_q    <= ex_alu_op_d;
      end
   end

   // Output wiring; forward data is the live WB result.
   always_comb begin
      ex_rs1_data  = ex_rs1_data_q;
      ex_rs2_data  = ex_rs2_data_q;
      ex_shamt     = ex_shamt_q;
      ex_fwd1      = ex_fwd1_q;
      ex_fwd2      = ex_fwd2_q;
      ex_shamt_sel = ex_shamt_sel_q;
      ex_rd_addr   = ex_rd_addr_q;
      ex_reg_write = ex_reg_write_q;
      ex_valid     = ex_valid_q;
      ex_alu_op    = ex_alu_op_q;
      ex_fwd_data  = wb_data;
      id_stall     = stall;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset sequence and
// randomized traffic against a behavioural model. Follows FORWARD_EN like the design.
module tb_id_ex_stage;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, id_valid, id_shamt_sel, id_reg_write, flush, wb_reg_write;
   logic [2:0] id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, wb_rd_addr;
   logic [7:0] id_rs1_data, id_rs2_data, id_shamt, wb_data;
   logic [7:0] ex_rs1_data, ex_rs2_data, ex_shamt, ex_fwd_data;
   logic       ex_fwd1, ex_fwd2, ex_shamt_sel, ex_reg_write, ex_valid, id_stall;
   logic [2:0] ex_rd_addr, ex_alu_op;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_shamt(id_shamt), .id_shamt_sel(id_shamt_sel), .id_rd_addr(id_rd_addr),
      .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_shamt(ex_shamt),
      .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2), .ex_shamt_sel(ex_shamt_sel),
      .ex_fwd_data(ex_fwd_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .id_stall(id_stall)
   );

   typedef struct {
      logic       rst, vld, shsel, rw, fl, wbrw;
      logic [2:0] rs1, rs2, rd, alu, wbrd;
      logic [7:0] d1, d2, sh, wbd;
   } in_t;

   // Expected contents of the EX stage; dk/sk mark whether data / shamt_sel are defined.
   typedef struct {
      logic       valid, rw, shsel, f1, f2, dk, sk;
      logic [2:0] rd, alu;
      logic [7:0] d1, d2, sh;
   } ex_t;

   // Two-bit expectations are {forward build, stall build}.
   typedef struct {
      in_t        i;
      logic [1:0] stall, valid, rw, fwd1, fwd2, chk1;
      logic [7:0] rs1d;
      logic       chksh;
      logic [7:0] sh;
   } row_t;

   int   n_checks = 0;
   int   n_fail = 0;
   ex_t  m;
   logic pre_stall;
   row_t rows[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic in_t mk(input logic rst, input logic vld, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] sh,
                              input logic shsel, input logic [2:0] rd, input logic rw,
                              input logic [2:0] alu, input logic fl, input logic wbrw,
                              input logic [2:0] wbrd, input logic [7:0] wbd);
      in_t v;
      v.rst = rst; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.d1 = d1; v.d2 = d2;
      v.sh = sh; v.shsel = shsel; v.rd = rd; v.rw = rw; v.alu = alu; v.fl = fl;
      v.wbrw = wbrw; v.wbrd = wbrd; v.wbd = wbd;
      return v;
   endfunction

   task automatic add_row(input in_t v, input logic [1:0] st, input logic [1:0] vl,
                          input logic [1:0] rw, input logic [1:0] f1,
                          input logic [1:0] f2, input logic [1:0] c1,
                          input logic [7:0] d1, input logic csh, input logic [7:0] sh);
      row_t r;
      r.i = v; r.stall = st; r.valid = vl; r.rw = rw; r.fwd1 = f1; r.fwd2 = f2;
      r.chk1 = c1; r.rs1d = d1; r.chksh = csh; r.sh = sh;
      rows.push_back(r);
   endtask

   function automatic in_t rnd_in();
      in_t v;
      v.rst = ($urandom_range(0, 19) == 0);
      v.fl = ($urandom_range(0, 6) == 0);
      v.vld = ($urandom_range(0, 4) != 0);
      v.rs1 = 3'($urandom_range(0, 3));
      v.rs2 = 3'($urandom_range(0, 3));
      v.rd = 3'($urandom_range(0, 3));
      v.wbrd = 3'($urandom_range(0, 3));
      v.alu = 3'($urandom);
      v.d1 = 8'($urandom);
      v.d2 = 8'($urandom);
      v.sh = 8'($urandom);
      v.wbd = 8'($urandom);
      v.shsel = 1'($urandom);
      v.rw = 1'($urandom);
      v.wbrw = 1'($urandom);
      return v;
   endfunction

   // Reference rules: a live ID source depends on a live writing producer in EX
   // (never r0); read values come from WB when WB writes that same nonzero register.
   function automatic bit depends(input ex_t e, input in_t v, input logic [2:0] a);
      return v.vld && e.valid && e.rw && a != 3'd0 && e.rd == a;
   endfunction

   function automatic bit model_stall(input ex_t e, input in_t v);
      bit h;
      h = depends(e, v, v.rs1) || (!v.shsel && depends(e, v, v.rs2));
      return !FWD && h && !v.fl && !v.rst;
   endfunction

   function automatic ex_t model_next(input ex_t e, input in_t v, input bit st);
      ex_t n = e;
      if (v.rst) begin
         n = '{default: '0};
         n.dk = 1'b1; n.sk = 1'b1;
      end else if (v.fl) begin
         n.valid = 0; n.rw = 0; n.f1 = 0; n.f2 = 0; n.shsel = 0; n.sk = 1; n.dk = 0;
      end else if (st) begin
         n.valid = 0; n.rw = 0; n.f1 = 0; n.f2 = 0; n.dk = 0; n.sk = 0;
      end else begin
         n.valid = v.vld;
         n.rw = v.rw && v.vld;
         n.rd = v.rd;
         n.alu = v.alu;
         n.sh = v.sh;
         n.shsel = v.shsel;
         n.d1 = (v.wbrw && v.wbrd != 0 && v.wbrd == v.rs1) ? v.wbd : v.d1;
         n.d2 = (v.wbrw && v.wbrd != 0 && v.wbrd == v.rs2) ? v.wbd : v.d2;
         n.f1 = FWD && depends(e, v, v.rs1);
         n.f2 = FWD && !v.shsel && depends(e, v, v.rs2);
         n.dk = 1; n.sk = 1;
      end
      return n;
   endfunction

   task automatic drive(input in_t v);
      reset = v.rst; id_valid = v.vld; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
      id_rs1_data = v.d1; id_rs2_data = v.d2; id_shamt = v.sh; id_shamt_sel = v.shsel;
      id_rd_addr = v.rd; id_reg_write = v.rw; id_alu_op = v.alu; flush = v.fl;
      wb_reg_write = v.wbrw; wb_rd_addr = v.wbrd; wb_data = v.wbd;
   endtask

   // One cycle: drive, check combinational outputs mid-cycle, clock, check registers.
   task automatic step(input in_t v);
      bit  st;
      ex_t nx;
      drive(v);
      @(negedge clk);
      st = model_stall(m, v);
      pre_stall = id_stall;
      chk("id_stall", id_stall, st);
      chk("ex_fwd_data", ex_fwd_data, v.wbd);
      nx = model_next(m, v, st);
      @(posedge clk);
      #1;
      m = nx;
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_reg_write", ex_reg_write, m.rw);
      chk("ex_fwd1", ex_fwd1, m.f1);
      chk("ex_fwd2", ex_fwd2, m.f2);
      if (m.sk) chk("ex_shamt_sel", ex_shamt_sel, m.shsel);
      if (m.dk) begin
         chk("ex_rs1_data", ex_rs1_data, m.d1);
         chk("ex_rs2_data", ex_rs2_data, m.d2);
         chk("ex_shamt", ex_shamt, m.sh);
         chk("ex_rd_addr", ex_rd_addr, m.rd);
         chk("ex_alu_op", ex_alu_op, m.alu);
      end
   endtask

   initial begin
      in_t v;
      m = '{default: '0};

      // Two reset cycles with random ID traffic: everything in EX must be zero.
      for (int c = 0; c < 2; c++) begin
         v = rnd_in();
         v.rst = 1'b1;
         step(v);
         chk("rst_stall", pre_stall, 1'b0);
         chk("rst_valid", ex_valid, 1'b0);
         chk("rst_reg_write", ex_reg_write, 1'b0);
         chk("rst_fwd", {ex_fwd1, ex_fwd2, ex_shamt_sel}, 8'h00);
         chk("rst_rs1", ex_rs1_data, 8'h00);
         chk("rst_rs2", ex_rs2_data, 8'h00);
         chk("rst_shamt", ex_shamt, 8'h00);
         chk("rst_rd_alu", {ex_rd_addr, ex_alu_op}, 8'h00);
      end

      //          rst vld rs1 rs2 d1     d2     sh     ss rd rw alu fl wbw wbr wbd
      // row 0: reset with a live instruction on the ID side
      add_row(mk(1, 1, 1, 2, 8'h11, 8'h22, 8'h00, 0, 3, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 8'h00, 1, 8'h00);
      // row 1: ADD r3
      add_row(mk(0, 1, 1, 2, 8'h11, 8'h22, 8'h00, 0, 3, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h11, 1, 8'h00);
      // row 2: SUB reads r3 right behind it: forward or stall
      add_row(mk(0, 1, 3, 2, 8'hEE, 8'h22, 8'h00, 0, 4, 1, 1, 0, 0, 0, 8'h00),
              2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 8'hEE, 0, 8'h00);
      // row 3: ID held, r3 now in WB with 5A
      add_row(mk(0, 1, 3, 2, 8'hEE, 8'h22, 8'h00, 0, 4, 1, 1, 0, 1, 3, 8'h5A),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h5A, 1, 8'h00);
      // row 4: shift by 3, rs2 matches EX rd but is not read
      add_row(mk(0, 1, 5, 4, 8'h10, 8'h20, 8'h03, 1, 5, 1, 2, 0, 0, 0, 8'h00),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h10, 1, 8'h03);
      // row 5: flush while a hazard is present
      add_row(mk(0, 1, 5, 1, 8'h10, 8'h20, 8'h00, 0, 6, 1, 3, 1, 0, 0, 8'h00),
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 8'h00);
      // row 6: producer targeting r0
      add_row(mk(0, 1, 1, 1, 8'h21, 8'h20, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h21, 1, 8'h00);
      // row 7: consumer reads r0 while WB writes r0: no hazard, no bypass
      add_row(mk(0, 1, 0, 0, 8'h33, 8'h34, 8'h00, 0, 6, 1, 0, 0, 1, 0, 8'h77),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h33, 1, 8'h00);
      // row 8: invalid ID matching the EX producer
      add_row(mk(0, 0, 6, 6, 8'h45, 8'h46, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 8'h45, 1, 8'h00);
      // rows 9-11: reset arriving in the stall cycle cancels it, then a normal load
      add_row(mk(0, 1, 1, 1, 8'h50, 8'h51, 8'h00, 0, 2, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h50, 1, 8'h00);
      add_row(mk(1, 1, 2, 1, 8'h44, 8'h51, 8'h00, 0, 3, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 8'h00, 1, 8'h00);
      add_row(mk(0, 1, 2, 1, 8'h44, 8'h51, 8'h00, 0, 3, 1, 0, 0, 0, 0, 8'h00),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h44, 1, 8'h00);
      // rows 12-13: rs2 dependency on r3, then r3 in WB
      add_row(mk(0, 1, 1, 3, 8'h01, 8'h99, 8'h00, 0, 4, 1, 0, 0, 0, 0, 8'h00),
              2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 8'h01, 0, 8'h00);
      add_row(mk(0, 1, 1, 3, 8'h01, 8'h99, 8'h00, 0, 4, 1, 0, 0, 1, 3, 8'hC3),
              2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 8'h01, 1, 8'h00);

      foreach (rows[k]) begin
         step(rows[k].i);
         chk($sformatf("row%0d_stall", k), pre_stall, rows[k].stall[FWD]);
         chk($sformatf("row%0d_valid", k), ex_valid, rows[k].valid[FWD]);
         chk($sformatf("row%0d_reg_write", k), ex_reg_write, rows[k].rw[FWD]);
         chk($sformatf("row%0d_fwd1", k), ex_fwd1, rows[k].fwd1[FWD]);
         chk($sformatf("row%0d_fwd2", k), ex_fwd2, rows[k].fwd2[FWD]);
         if (rows[k].chk1[FWD]) chk($sformatf("row%0d_rs1", k), ex_rs1_data, rows[k].rs1d);
         if (rows[k].chksh) chk($sformatf("row%0d_shamt", k), ex_shamt, rows[k].sh);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) step(rnd_in());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
